// File: rtl/sipo_if.sv
// Serial-in / parallel-out deserialiser bus.
// Serial side in, word side out with a valid/ready handshake.
interface sipo_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
);
  logic             si;
  logic             si_valid;
  logic             frame_start;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;
  logic             overrun;
  logic             clr_ovr;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output si, si_valid, frame_start,
    output po_ready, clr_ovr,
    input  po, po_valid, overrun, bit_cnt
  );

  modport slave (
    input  si, si_valid, frame_start,
    input  po_ready, clr_ovr,
    output po, po_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/sipo_deser.sv
// Parametrised deserialiser: assembles WIDTH serial bits into a word
// held in an output register until the consumer accepts it.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic   clk,
  input  logic   rst,
  sipo_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] po_q;
  logic [CW-1:0]    cnt;
  logic             ovr_q;
  logic             last;
  logic             done;

  // seed is the word holding only the first bit of a fresh frame
  always_comb begin
    shifted = '0;
    seed    = '0;
    if (MSB_FIRST != 0) begin
      shifted = {sreg[WIDTH-2:0], bus.si};
      seed    = {{(WIDTH-1){1'b0}}, bus.si};
    end else begin
      shifted = {bus.si, sreg[WIDTH-1:1]};
      seed    = {bus.si, {(WIDTH-1){1'b0}}};
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));
  assign done = bus.si_valid && !bus.frame_start && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg  <= '0;
      cnt   <= '0;
      po_q  <= '0;
      ovr_q <= 1'b0;
      state <= EMPTY;
    end else begin
      if (bus.frame_start) begin
        sreg <= bus.si_valid ? seed : '0;
        cnt  <= bus.si_valid ? CW'(1) : '0;
      end else if (bus.si_valid) begin
        if (last) begin
          sreg <= '0;
          cnt  <= '0;
        end else begin
          sreg <= shifted;
          cnt  <= cnt + CW'(1);
        end
      end

      unique case (state)
        EMPTY: begin
          if (done) begin
            po_q  <= shifted;
            state <= FULL;
          end
        end
        FULL: begin
          if (done) begin
            if (bus.po_ready) po_q <= shifted;
          end else if (bus.po_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase

      // a fresh drop outranks a simultaneous clear
      if (state == FULL && done && !bus.po_ready)
        ovr_q <= 1'b1;
      else if (bus.clr_ovr)
        ovr_q <= 1'b0;
    end
  end

  assign bus.po       = po_q;
  assign bus.po_valid = (state == FULL);
  assign bus.overrun  = ovr_q;
  assign bus.bit_cnt  = cnt;
endmodule
